pool_sched: RTL

- Sequencer for the POOL datapath. Takes one layer-level pooling configuration and walks every PEL psum tile of every frame through POOL.
- Per tile: waits for PEL to mark the tile ready, drives CFG_POOL and a one-cycle POOL_Val, waits for POOL completion, then releases the tile back to PEL.
- Owns the frame-pair parity that selects 2x1x1 frame pooling (POOL_ValFrm). Sits between the top-level layer controller, PEL and POOL.

---
 rtl/pool_sched.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pool_sched.sv
// Tile sequencer for the POOL datapath: walks every PEL psum tile of every frame through POOL.
// Optional RUN watchdog with sticky Err is enabled by defining POOL_SCHED_TIMEOUT_EN.
module pool_sched #(
    parameter int FL_WIDTH     = 5,
    parameter int STRIDE_WIDTH = 2,
    parameter int CNT_WIDTH    = 8,
    parameter int TO_WIDTH     = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             CFG_Val,
    input  logic [FL_WIDTH-1:0]              CFG_Fl,
    input  logic [STRIDE_WIDTH-1:0]          CFG_Stride,
    input  logic                             CFG_FrmPool,
    input  logic [CNT_WIDTH-1:0]             CFG_NumTile,
    input  logic [CNT_WIDTH-1:0]             CFG_NumFrm,
    input  logic                             PEL_Rdy,
    output logic                             PEL_Rel,
    input  logic                             POOL_Fnh,
    output logic [FL_WIDTH+STRIDE_WIDTH:0]   CFG_POOL,
    output logic                             POOL_Val,
    output logic                             Busy,
    output logic                             Done,
    output logic                             Err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_REL    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]              state;
    logic [2:0]              state_nxt;
    logic [FL_WIDTH-1:0]     fl_q;
    logic [STRIDE_WIDTH-1:0] stride_q;
    logic                    frm_pool_q;
    logic [CNT_WIDTH-1:0]    num_tile_q;
    logic [CNT_WIDTH-1:0]    num_frm_q;
    logic [CNT_WIDTH-1:0]    tile_cnt;
    logic [CNT_WIDTH-1:0]    frm_cnt;
    logic [STRIDE_WIDTH-1:0] stride_in;
    logic                    last_tile;
    logic                    last_frm;
    logic                    to_expire;

    // POOL only implements strides 2 and 3; anything below 2 falls back to 2.
    assign stride_in = (CFG_Stride < STRIDE_WIDTH'(2)) ? STRIDE_WIDTH'(2) : CFG_Stride;
    assign last_tile = (tile_cnt == num_tile_q);
    assign last_frm  = (frm_cnt == num_frm_q);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (CFG_Val) state_nxt = S_WAIT;
            S_WAIT:   if (PEL_Rdy) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_RUN;
            S_RUN:    if (POOL_Fnh || to_expire) state_nxt = S_REL;
            S_REL:    state_nxt = (last_tile && last_frm) ? S_DONE : S_WAIT;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // CFG_POOL only moves on entry to WAIT, so POOL sees a stable word for the whole tile.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            fl_q       <= '0;
            stride_q   <= '0;
            frm_pool_q <= 1'b0;
            num_tile_q <= '0;
            num_frm_q  <= '0;
            tile_cnt   <= '0;
            frm_cnt    <= '0;
            CFG_POOL   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (CFG_Val) begin
                        fl_q       <= CFG_Fl;
                        stride_q   <= stride_in;
                        frm_pool_q <= CFG_FrmPool;
                        num_tile_q <= CFG_NumTile;
                        num_frm_q  <= CFG_NumFrm;
                        tile_cnt   <= '0;
                        frm_cnt    <= '0;
                        CFG_POOL   <= {CFG_Fl, 1'b0, stride_in};
                    end
                end
                S_REL: begin
                    if (!last_tile) begin
                        tile_cnt <= tile_cnt + CNT_WIDTH'(1);
                        CFG_POOL <= {fl_q, frm_pool_q & frm_cnt[0], stride_q};
                    end else if (!last_frm) begin
                        tile_cnt <= '0;
                        frm_cnt  <= frm_cnt + CNT_WIDTH'(1);
                        CFG_POOL <= {fl_q, frm_pool_q & ~frm_cnt[0], stride_q};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef POOL_SCHED_TIMEOUT_EN
    logic [TO_WIDTH-1:0] to_cnt;
    logic                err_q;

    // A finish arriving on the expiry cycle wins over the watchdog.
    assign to_expire = (state == S_RUN) && (&to_cnt) && !POOL_Fnh;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == S_LAUNCH) begin
                to_cnt <= '0;
            end else if (state == S_RUN) begin
                to_cnt <= to_cnt + TO_WIDTH'(1);
            end
            if (to_expire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign Err = err_q;
`else
    assign to_expire = 1'b0;
    // Watchdog absent: Err is constant 0 whatever TO_WIDTH is set to.
    assign Err = 1'b0 && (TO_WIDTH > 0);
`endif

    assign POOL_Val = (state == S_LAUNCH);
    assign PEL_Rel  = (state == S_REL);
    assign Done     = (state == S_DONE);
    assign Busy     = (state != S_IDLE);

endmodule
